// File: rtl/edge_reconstructor.sv
// Rebuilds a level waveform from rise/fall event pulses; every applied level holds for at least MIN_WIDTH cycles.
// Optional EDGE_RECON_CANCEL_EN: a legal event annihilates the unpopped FIFO tail instead of being pushed.
module edge_reconstructor #(
  parameter int MIN_WIDTH = 4,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pos,
  input  logic                         neg,
  input  logic                         clr,
  output logic                         out,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         err,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] fifo_q;
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic [7:0]       hold_q;
  logic             out_q, err_q, ovf_q;

  logic          rise, fall, both, tail, legal, redundant;
  logic          pop, push, cancel, drop;
  logic [PW-1:0] last_ptr;
  logic [CW-1:0] cnt_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rise      = pos & ~neg;
    fall      = neg & ~pos;
    both      = pos & neg;
    last_ptr  = (wr_q == '0) ? PW'(DEPTH-1) : wr_q - PW'(1);
    // With the FIFO empty the tail is whatever is already on out.
    tail      = (cnt_q == '0) ? out_q : fifo_q[last_ptr];
    legal     = (rise && !tail) || (fall && tail);
    redundant = (rise && tail) || (fall && !tail);
    pop       = (hold_q == 8'd0) && (cnt_q != '0);
`ifdef EDGE_RECON_CANCEL_EN
    cancel    = legal && ((cnt_q > CW'(1)) || ((cnt_q == CW'(1)) && !pop));
`else
    cancel    = 1'b0;
`endif
    push      = legal && !cancel && ((cnt_q < CW'(DEPTH)) || pop);
    drop      = legal && !cancel && !push;
    cnt_n     = cnt_q + CW'(push) - CW'(pop) - CW'(cancel);
  end

  // Event storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      hold_q <= 8'd0;
      out_q  <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      if (pop) begin
        rd_q   <= ptr_inc(rd_q);
        out_q  <= fifo_q[rd_q];
        hold_q <= 8'(MIN_WIDTH-1);
      end else if (hold_q != 8'd0) begin
        hold_q <= hold_q - 8'd1;
      end
      if (push)        wr_q <= ptr_inc(wr_q);
      else if (cancel) wr_q <= last_ptr;
      // A set condition in the same cycle overrides clr.
      if (both || redundant) err_q <= 1'b1;
      else if (clr)          err_q <= 1'b0;
      if (drop)              ovf_q <= 1'b1;
      else if (clr)          ovf_q <= 1'b0;
    end
  end

  assign out      = out_q;
  assign pending  = cnt_q;
  assign busy     = (cnt_q != '0) || (hold_q != 8'd0);
  assign err      = err_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_reconstructor.sv
// Self-checking bench for edge_reconstructor using a queue-based reference model of the event stream.
module tb_edge_reconstructor;
  localparam int MW    = 4;
  localparam int DEPTH = 4;
  localparam int PCW   = $clog2(DEPTH+1);

  logic clk = 1'b0, rst_n = 1'b0, pos = 1'b0, neg = 1'b0, clr = 1'b0;
  logic out, busy, err, overflow;
  logic [PCW-1:0] pending;
  int total = 0, bad = 0;

  edge_reconstructor #(.MIN_WIDTH(MW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pos(pos), .neg(neg), .clr(clr),
    .out(out), .busy(busy), .pending(pending), .err(err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending events are a queue of target levels.
  bit m_out, m_err, m_ovf;
  int m_hold;
  bit mq[$];

  wire [PCW+3:0] dut_vec = {out, busy, pending, err, overflow};

  function automatic logic [PCW+3:0] exp_vec();
    logic b;
    b = (mq.size() != 0) || (m_hold != 0);
    return {m_out, b, PCW'(mq.size()), m_err, m_ovf};
  endfunction

  task automatic model_reset();
    mq.delete(); m_out = 0; m_hold = 0; m_err = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit p, input bit n, input bit c);
    bit tail, e_set, o_set;
    e_set = 0; o_set = 0;
    tail = (mq.size() != 0) ? mq[mq.size()-1] : m_out;
    if (m_hold == 0 && mq.size() != 0) begin
      m_out = mq.pop_front();
      m_hold = MW - 1;
    end else if (m_hold > 0) m_hold--;
    if (p && n) e_set = 1;
    else if (p || n) begin
      if (p == tail) e_set = 1;
`ifdef EDGE_RECON_CANCEL_EN
      else if (mq.size() != 0) void'(mq.pop_back());
`endif
      else if (mq.size() < DEPTH) mq.push_back(p);
      else o_set = 1;
    end
    m_err = e_set ? 1'b1 : (c ? 1'b0 : m_err);
    m_ovf = o_set ? 1'b1 : (c ? 1'b0 : m_ovf);
  endtask

  task automatic edge_step(input bit p, input bit n, input bit c);
    pos = p; neg = n; clr = c;
    @(posedge clk);
    model_step(p, n, c);
    #1;
    pos = 0; neg = 0; clr = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0;
    #3;
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset got=%b want=%b", dut_vec, exp_vec());
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_latency();
    edge_step(1, 0, 0);
    total++;
    if (pending !== PCW'(1) || out !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL latency_push got out=%b pend=%0d busy=%b want 0/1/1", out, pending, busy);
    end
    for (int i = 0; i < 4; i++) begin
      edge_step(0, 0, 0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL latency_idle%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (out !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL latency_end got out=%b busy=%b want 1/0", out, busy);
    end
  endtask

  task automatic test_pulse_width();
    int hi;
    edge_step(0, 1, 0);
    for (int i = 0; i < 5; i++) edge_step(0, 0, 0);
    edge_step(1, 0, 0);
    edge_step(0, 1, 0);
    hi = out ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      edge_step(0, 0, 0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL width_step%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
      if (out) hi++;
    end
    total++;
    if (hi != MW || err !== 1'b0) begin
      bad++; $display("FAIL width_high got hi=%0d err=%b want %0d/0", hi, err, MW);
    end
  endtask

  task automatic test_overflow();
    int toggles, last_t, t;
    bit prev;
    toggles = 0; last_t = -1; t = 0; prev = out;
    for (int i = 0; i < 37; i++) begin
      edge_step((i < 7) && (i % 2 == 0), (i < 7) && (i % 2 == 1), 0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL ovf_step%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
      if (i == 4) begin
        total++;
        if (pending !== PCW'(4)) begin
          bad++; $display("FAIL ovf_full got=%0d want=4", pending);
        end
      end
      if (i == 6) begin
        total++;
        if (overflow !== 1'b1) begin
          bad++; $display("FAIL ovf_flag got=%b want=1", overflow);
        end
      end
      if (out != prev) begin
        if (last_t >= 0) begin
          total++;
          if (t - last_t != MW) begin
            bad++; $display("FAIL ovf_gap got=%0d want=%0d", t - last_t, MW);
          end
        end
        last_t = t; toggles++;
      end
      prev = out; t++;
    end
    total++;
    if (toggles != 6) begin
      bad++; $display("FAIL ovf_toggles got=%0d want=6", toggles);
    end
    edge_step(0, 0, 1);
    total++;
    if (dut_vec !== exp_vec() || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clr got=%b want=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_both_err();
    edge_step(1, 1, 0);
    total++;
    if (dut_vec !== exp_vec() || err !== 1'b1 || pending !== '0) begin
      bad++; $display("FAIL both_err got=%b want=%b", dut_vec, exp_vec());
    end
    edge_step(0, 0, 1);
    total++;
    if (dut_vec !== exp_vec() || err !== 1'b0) begin
      bad++; $display("FAIL both_clr got=%b want=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_redundant_async_reset();
    edge_step(1, 0, 0);
    for (int i = 0; i < 5; i++) edge_step(0, 0, 0);
    edge_step(1, 0, 0);
    total++;
    if (err !== 1'b1 || pending !== '0 || out !== 1'b1) begin
      bad++; $display("FAIL redundant got err=%b pend=%0d out=%b want 1/0/1", err, pending, out);
    end
    edge_step(0, 1, 0);
    for (int i = 0; i < 5; i++) edge_step(0, 0, 0);
    edge_step(1, 0, 0);
    edge_step(0, 1, 0);
    edge_step(1, 0, 0);
    total++;
    if (dut_vec !== exp_vec() || out !== 1'b1 || pending !== PCW'(2)) begin
      bad++; $display("FAIL prereset got=%b want=%b", dut_vec, exp_vec());
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    total++;
    if (dut_vec !== exp_vec() || dut_vec !== '0) begin
      bad++; $display("FAIL async_reset got=%b want=%b", dut_vec, exp_vec());
    end
    @(negedge clk); rst_n = 1;
  endtask

`ifdef EDGE_RECON_CANCEL_EN
  task automatic test_cancel();
    edge_step(1, 0, 0);
    edge_step(0, 1, 0);
    edge_step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      edge_step(0, 0, 0);
      total++;
      if (dut_vec !== exp_vec() || out !== 1'b1 || pending !== '0) begin
        bad++; $display("FAIL cancel_step%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
    end
  endtask
`endif

  task automatic test_random();
    int r;
    bit p, n, c;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      p = (r < 3) || (r == 9);
      n = (r >= 3 && r < 6) || (r == 9);
      c = ($urandom_range(0, 15) == 0);
      edge_step(p, n, c);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random%0d got=%b want=%b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_pulse_width();
    test_overflow();
    test_both_err();
    test_redundant_async_reset();
`ifdef EDGE_RECON_CANCEL_EN
    test_cancel();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_reconstructor.md
Name: edge_reconstructor

Overview:
- Inverse of the edge-detect path: consumes single-cycle rise/fall event pulses (pos/neg) and rebuilds a level waveform on out.
- Every level on out holds for at least MIN_WIDTH cycles.
- Events arriving faster than that are buffered in a small FIFO and replayed in order.
- Sits downstream of edge-detect logic, or drives any consumer that needs a debounced, width-guaranteed level from edge events.

Parameters:
- MIN_WIDTH, 4: minimum cycles out holds a level after any applied edge; legal range 1..255.
- DEPTH, 4: pending-event FIFO depth; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pos  input  1  rise-event pulse, sampled each clk edge
- neg  input  1  fall-event pulse, sampled each clk edge
- clr  input  1  synchronous clear of sticky err/overflow
- out  output  1  reconstructed level
- busy  output  1  FIFO non-empty or hold counter non-zero
- pending  output  $clog2(DEPTH+1)  current FIFO occupancy
- err  output  1  sticky: illegal or redundant event seen
- overflow  output  1  sticky: legal event dropped, FIFO full

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate, no clock needed): out=0, busy=0, pending=0, err=0, overflow=0, hold=0, tail level=0, FIFO emptied. Applies mid-operation; all queued events are discarded.
- Tail level: level after the last queued event, or out when the FIFO is empty.
- Event classification per edge:
  - pos=1,neg=0 -> RISE.
  - pos=0,neg=1 -> FALL.
  - Both high -> err<=1, nothing queued.
  - Neither -> no event.
- Redundant event (RISE with tail level 1, or FALL with tail level 0): err<=1, dropped.
- Apply rule: at an edge where hold==0 and the FIFO is non-empty: pop head, out<=head level, hold<=MIN_WIDTH-1. Otherwise, if hold!=0, hold decrements.
- Latency: event sampled at edge k with FIFO empty and hold==0 -> out changes at edge k+1. Each level lasts >= MIN_WIDTH cycles. MIN_WIDTH=1 allows an applied edge every cycle.
- Push rule: a legal event is accepted if count<DEPTH, or if a pop occurs in the same edge (pop-then-push).
  - Otherwise overflow<=1, event dropped, tail level unchanged.
  - An event sampled at the same edge its FIFO would otherwise pop is queued, never bypassed.
- pending = occupancy after the edge's pop/push. busy = (pending!=0) || (hold!=0).
- clr=1: err<=0, overflow<=0. Set conditions in the same cycle win over clr. FIFO/out unaffected.
- Wrap-around: FIFO pointers wrap modulo DEPTH; occupancy never exceeds DEPTH.

Optional Feature:
- Macro EDGE_RECON_CANCEL_EN.
- Defined: a legal event arriving while the FIFO holds >=1 entry not being popped this edge removes the tail entry instead of pushing (glitch annihilation):
  - pending decrements.
  - Tail level reverts.
  - No overflow is possible on a cancel.
- Undefined: every legal event is pushed per the push rule.

Test Plan (MIN_WIDTH=4, DEPTH=4, macro undefined unless stated):
- Reset, pos at edge 2 -> pending=1 after edge 2; out=1 from edge 3; busy high edges 2..5, low after edge 6.
- pos at edge 10, neg at edge 11 -> out=1 at edge 11, out=0 at edge 15 (high exactly 4 cycles); err=0.
- Alternating events on edges 20..26 starting RISE:
  - pending reaches 4 at edge 24.
  - The edge-26 event is dropped and overflow=1.
  - out replays 6 edges, each level 4 cycles.
- pos=neg=1 at an edge -> err=1, out and pending unchanged. clr next edge -> err=0.
- out=1 idle, pos pulse -> err=1, pending stays 0. Then rst_n low between edges while out=1, pending=2 -> out=0, pending=0, busy=0, err=0 immediately.
- EDGE_RECON_CANCEL_EN defined: pos at edge 30, neg at 31, pos at 32 -> out high from 31, the neg/pos pair cancels, out stays 1 through edge 40, pending=0.
